// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames TX FIFO bytes per line control and shifts them out LSB first on txd
module uart_tx_serializer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       baud_tick,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  input  logic       fifo_rempty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rinc,
  output logic       txd,
  output logic       tx_busy,
  output logic       temt
);
  localparam int TW = $clog2(2*OVERSAMPLE+1);
  localparam logic [TW-1:0] T1  = TW'(OVERSAMPLE);
  localparam logic [TW-1:0] T15 = TW'(OVERSAMPLE*3/2);
  localparam logic [TW-1:0] T2  = TW'(2*OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tick_cnt, bit_len;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [1:0] wls_r;
  logic stb_r, pen_r, par_r, txd_r, txd_nx, bit_state, bit_done, last_bit, par_nx;
  assign bit_state = state inside {START, DATA, PARITY, STOP};
  assign bit_len   = state != STOP ? T1 : !stb_r ? T1 : wls_r == 2'b00 ? T15 : T2;
  assign bit_done  = bit_state && baud_tick && tick_cnt == bit_len - TW'(1);
  assign last_bit  = bit_cnt == {1'b0, wls_r} + 3'd4;
  assign par_nx    = sp ? ~eps : eps ? ^(fifo_data & (8'hFF >> (2'd3 - wls))) : ~^(fifo_data & (8'hFF >> (2'd3 - wls)));
  assign fifo_rinc = state == POP;
  assign tx_busy   = state != IDLE;
  assign temt      = fifo_rempty && state == IDLE;
  assign txd       = txd_r & ~bc;
  // next-state sequencing through the frame
  always_comb begin
    state_nx = state;
    txd_nx = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_r : 1'b1;
    case (state)
      IDLE:    state_nx = fifo_rempty ? IDLE : POP;
      POP:     state_nx = LOAD;
      LOAD:    state_nx = START;
      START:   state_nx = bit_done ? DATA : START;
      DATA:    state_nx = !(bit_done && last_bit) ? DATA : pen_r ? PARITY : STOP;
      PARITY:  state_nx = bit_done ? STOP : PARITY;
      STOP:    state_nx = !bit_done ? STOP : fifo_rempty ? IDLE : POP;
      default: state_nx = IDLE;
    endcase
  end
  // state, counters, frame latches and registered serial output
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wls_r    <= '0;
      stb_r    <= 1'b0;
      pen_r    <= 1'b0;
      par_r    <= 1'b0;
      txd_r    <= 1'b1;
    end else begin
      state    <= state_nx;
      txd_r    <= txd_nx;
      tick_cnt <= (!bit_state || bit_done) ? '0 : tick_cnt + TW'(baud_tick);
      bit_cnt  <= state != DATA ? '0 : bit_cnt + 3'(bit_done && !last_bit);
      if (state == LOAD) begin
        shift <= fifo_data;
        wls_r <= wls;
        stb_r <= stb;
        pen_r <= pen;
        par_r <= par_nx;
      end else if (state == DATA && bit_done) begin
        shift <= shift >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frame checks against hand-computed line waveforms
module tb_uart_tx_serializer;
  logic clk = 1'b0, rst_ = 1'b0, baud_tick = 1'b1, stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, bc = 1'b0;
  logic [1:0] wls = 2'b11;
  logic [7:0] fifo_data = '0;
  logic fifo_rempty, fifo_rinc, txd, tx_busy, temt;
  logic [7:0] mem [16];
  int wr = 0, rd = 0, rinc_cnt = 0, checks = 0, errors = 0, len;
  logic samp [1024];
  always #5 clk = ~clk;
  assign fifo_rempty = (wr == rd);
  uart_tx_serializer dut (.clk(clk), .rst_(rst_), .baud_tick(baud_tick), .wls(wls), .stb(stb), .pen(pen),
    .eps(eps), .sp(sp), .bc(bc), .fifo_rempty(fifo_rempty), .fifo_data(fifo_data), .fifo_rinc(fifo_rinc),
    .txd(txd), .tx_busy(tx_busy), .temt(temt));
  always @(posedge clk) if (fifo_rinc) begin
    fifo_data <= mem[rd % 16];
    rd <= rd + 1;
  end
  always @(negedge clk) if (fifo_rinc) rinc_cnt++;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(logic [7:0] b);
    mem[wr % 16] = b;
    wr++;
  endtask
  task automatic cfg(logic [1:0] w, logic s, logic p, logic e, logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask
  task automatic wait_rinc(string tag);
    int t = 0;
    while (!fifo_rinc && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!fifo_rinc) check({tag, "_rinc_timeout"}, 0, 1);
  endtask
  task automatic capture(string tag, output int n);
    n = 0;
    wait_rinc(tag);
    while (tx_busy && n < 1000) begin
      samp[n] = txd;
      n++;
      @(negedge clk);
    end
  endtask
  function automatic logic bit_at(int off, int k);
    return samp[off + 11 + 16*k];
  endfunction
  task automatic frame_chk(string tag, int off, int nb, logic p, logic [7:0] exp_d, logic exp_p);
    logic [7:0] d = '0;
    for (int i = 0; i < nb; i++) d[i] = bit_at(off, 1 + i);
    check({tag, "_start"}, 32'(bit_at(off, 0)), 0);
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    if (p) check({tag, "_parity"}, 32'(bit_at(off, 1 + nb)), 32'(exp_p));
    check({tag, "_stop"}, 32'(bit_at(off, 1 + nb + 32'(p))), 1);
  endtask
  task automatic send(string tag, logic [7:0] b, int nb, logic p, logic [7:0] exp_d, logic exp_p, int exp_len);
    int r0 = rinc_cnt;
    push(b);
    capture(tag, len);
    frame_chk(tag, 0, nb, p, exp_d, exp_p);
    check({tag, "_busy_len"}, 32'(len), 32'(exp_len));
    check({tag, "_rinc"}, 32'(rinc_cnt - r0), 1);
    check({tag, "_temt"}, 32'(temt), 1);
  endtask
  initial begin
    int r0, low;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_rinc", 32'(fifo_rinc), 0);
    check("rst_temt", 32'(temt), 1);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    cfg(2'b11, 0, 0, 0, 0);
    send("8n1_a5", 8'hA5, 8, 0, 8'hA5, 0, 162);
    cfg(2'b10, 0, 1, 1, 0);
    send("7e1_35", 8'h35, 7, 1, 8'h35, 0, 162);
    cfg(2'b10, 0, 1, 0, 0);
    send("7o1_35", 8'h35, 7, 1, 8'h35, 1, 162);
    cfg(2'b11, 0, 1, 0, 1);
    send("stick_e0", 8'h35, 8, 1, 8'h35, 1, 178);
    cfg(2'b11, 0, 1, 1, 1);
    send("stick_e1", 8'h35, 8, 1, 8'h35, 0, 178);
    cfg(2'b00, 1, 0, 0, 0);
    send("5n15_1f", 8'hFF, 5, 0, 8'h1F, 0, 122);
    cfg(2'b11, 1, 0, 0, 0);
    send("8n2_5a", 8'h5A, 8, 0, 8'h5A, 0, 178);
    cfg(2'b11, 0, 0, 0, 0);
    r0 = rinc_cnt;
    push(8'h11);
    push(8'h22);
    fork
      capture("b2b", len);
      begin
        repeat (200) @(negedge clk);
        check("b2b_temt_mid", 32'(temt), 0);
      end
    join
    frame_chk("b2b_f1", 0, 8, 0, 8'h11, 0);
    frame_chk("b2b_f2", 162, 8, 0, 8'h22, 0);
    check("b2b_busy_len", 32'(len), 324);
    check("b2b_rinc", 32'(rinc_cnt - r0), 2);
    check("b2b_temt_end", 32'(temt), 1);
    push(8'hFF);
    fork
      capture("bc", len);
      begin
        wait_rinc("bc_w");
        repeat (60) @(negedge clk);
        #1 bc = 1'b1;
        #1 check("bc_force", 32'(txd), 0);
        repeat (10) @(negedge clk);
        check("bc_hold", 32'(txd), 0);
        #1 bc = 1'b0;
        #1 check("bc_restore", 32'(txd), 1);
      end
    join
    check("bc_busy_len", 32'(len), 162);
    check("bc_data", 32'(bit_at(0, 4)), 1);
    push(8'h00);
    wait_rinc("rst");
    repeat (40) @(negedge clk);
    check("rst_mid_txd0", 32'(txd), 0);
    #1 rst_ = 1'b0;
    #1 check("rst_mid_txd", 32'(txd), 1);
    check("rst_mid_busy", 32'(tx_busy), 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    check("rst_mid_temt", 32'(temt), 1);
    r0 = rinc_cnt;
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!txd) low++;
    end
    check("idle_txd_low", 32'(low), 0);
    check("idle_rinc", 32'(rinc_cnt - r0), 0);
    check("idle_temt", 32'(temt), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
